// File: rtl/spi_cmd_sequencer_if.sv
// Byte-stream and register-bank signals between the SPI command sequencer
// (master side) and the RX FIFO / TX FIFO / register bank (slave side).
interface spi_cmd_sequencer_if #(
  parameter int ADDR_WIDTH = 7
);
  logic [7:0]            rx_data;
  logic                  rx_empty;
  logic                  rx_read;
  logic [7:0]            tx_data;
  logic                  tx_write;
  logic                  tx_full;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [7:0]            reg_wdata;
  logic                  reg_we;
  logic                  reg_re;
  logic [7:0]            reg_rdata;

  modport master (
    input  rx_data, rx_empty, tx_full, reg_rdata,
    output rx_read, tx_data, tx_write, reg_addr, reg_wdata, reg_we, reg_re
  );

  modport slave (
    output rx_data, rx_empty, tx_full, reg_rdata,
    input  rx_read, tx_data, tx_write, reg_addr, reg_wdata, reg_we, reg_re
  );
endinterface

// File: rtl/spi_cmd_sequencer.sv
// Parses SPI command frames (header, length, payload) into register writes or
// reads; define SPI_SEQ_CHECKSUM_EN to add a trailing XOR checksum byte.
module spi_cmd_sequencer #(
  parameter int ADDR_WIDTH     = 7,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  spi_cmd_sequencer_if.master bus,
  input  logic                frame_abort,
  input  logic                err_clear,
  output logic                busy,
  output logic                error,
  output logic [7:0]          frame_count
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_HDR      = 4'd1;
  localparam logic [3:0] ST_LEN      = 4'd2;
  localparam logic [3:0] ST_WR_FETCH = 4'd3;
  localparam logic [3:0] ST_WR_DO    = 4'd4;
  localparam logic [3:0] ST_RD_REQ   = 4'd5;
  localparam logic [3:0] ST_RD_PUSH  = 4'd6;
  localparam logic [3:0] ST_DONE     = 4'd7;
`ifdef SPI_SEQ_CHECKSUM_EN
  localparam logic [3:0] ST_CK_FETCH = 4'd8;
  localparam logic [3:0] ST_CK_CHK   = 4'd9;
  localparam logic [3:0] ST_RD_CK    = 4'd10;
  localparam logic [3:0] ST_WR_END   = ST_CK_FETCH;
  localparam logic [3:0] ST_RD_END   = ST_RD_CK;
`else
  localparam logic [3:0] ST_WR_END   = ST_DONE;
  localparam logic [3:0] ST_RD_END   = ST_DONE;
`endif

  logic [3:0]            state_reg, state_next;
  logic                  dir_reg, dir_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [7:0]            len_reg, len_next;
  logic [7:0]            hold_reg, hold_next;
  logic                  held_reg, held_next;
  logic                  pend_reg;
  logic [TW-1:0]         tmo_reg, tmo_next;
  logic                  error_reg, error_next;
  logic [7:0]            fcnt_reg, fcnt_next;
`ifdef SPI_SEQ_CHECKSUM_EN
  logic [7:0]            csum_reg, csum_next;
`endif

  logic       pop, we, re, push, err_set, abort_hit, fetch_wait;
  logic [7:0] wdata, tdata, rd_byte;

  always_comb begin
    state_next = state_reg;
    dir_next   = dir_reg;
    addr_next  = addr_reg;
    len_next   = len_reg;
    hold_next  = hold_reg;
    held_next  = held_reg;
    tmo_next   = '0;
    fcnt_next  = fcnt_reg;
`ifdef SPI_SEQ_CHECKSUM_EN
    csum_next  = csum_reg;
`endif
    pop        = 1'b0;
    we         = 1'b0;
    re         = 1'b0;
    push       = 1'b0;
    wdata      = 8'h00;
    tdata      = 8'h00;
    err_set    = 1'b0;
    fetch_wait = 1'b0;
    rd_byte    = held_reg ? hold_reg : bus.reg_rdata;
    abort_hit  = frame_abort && (state_reg != ST_IDLE) && (state_reg != ST_DONE);

    case (state_reg)
      ST_IDLE: begin
        if (!bus.rx_empty) begin
          pop        = 1'b1;
          state_next = ST_HDR;
        end
      end
      ST_HDR: begin
        fetch_wait = 1'b1;
        // The header arrives one cycle after its pop; the next pop waits a
        // cycle so pops are never back-to-back.
        if (pend_reg) begin
          dir_next  = bus.rx_data[7];
          addr_next = bus.rx_data[ADDR_WIDTH-1:0];
`ifdef SPI_SEQ_CHECKSUM_EN
          csum_next = bus.rx_data;
`endif
        end else if (!bus.rx_empty) begin
          pop        = 1'b1;
          state_next = ST_LEN;
        end
      end
      ST_LEN: begin
        fetch_wait = 1'b1;
        len_next   = bus.rx_data;
`ifdef SPI_SEQ_CHECKSUM_EN
        csum_next  = csum_reg ^ bus.rx_data;
`endif
        if (bus.rx_data == 8'h00)
          state_next = dir_reg ? ST_WR_END : ST_RD_END;
        else
          state_next = dir_reg ? ST_WR_FETCH : ST_RD_REQ;
      end
      ST_WR_FETCH: begin
        fetch_wait = 1'b1;
        if (!bus.rx_empty) begin
          pop        = 1'b1;
          state_next = ST_WR_DO;
        end
      end
      ST_WR_DO: begin
        we        = 1'b1;
        wdata     = bus.rx_data;
        addr_next = addr_reg + ADDR_WIDTH'(1);
        len_next  = len_reg - 8'd1;
`ifdef SPI_SEQ_CHECKSUM_EN
        csum_next = csum_reg ^ bus.rx_data;
`endif
        state_next = (len_reg == 8'd1) ? ST_WR_END : ST_WR_FETCH;
      end
      ST_RD_REQ: begin
        re         = 1'b1;
        held_next  = 1'b0;
        state_next = ST_RD_PUSH;
      end
      ST_RD_PUSH: begin
        // Under backpressure the read byte is parked in hold_reg so the
        // register (which may have read side effects) is never re-read.
        tdata     = rd_byte;
        hold_next = rd_byte;
        if (!bus.tx_full) begin
          push      = 1'b1;
          held_next = 1'b0;
          addr_next = addr_reg + ADDR_WIDTH'(1);
          len_next  = len_reg - 8'd1;
`ifdef SPI_SEQ_CHECKSUM_EN
          csum_next = csum_reg ^ rd_byte;
`endif
          state_next = (len_reg == 8'd1) ? ST_RD_END : ST_RD_REQ;
        end else begin
          held_next = 1'b1;
        end
      end
`ifdef SPI_SEQ_CHECKSUM_EN
      ST_CK_FETCH: begin
        fetch_wait = 1'b1;
        if (!bus.rx_empty) begin
          pop        = 1'b1;
          state_next = ST_CK_CHK;
        end
      end
      ST_CK_CHK: begin
        if (bus.rx_data != csum_reg)
          err_set = 1'b1;
        state_next = ST_DONE;
      end
      ST_RD_CK: begin
        tdata = csum_reg;
        if (!bus.tx_full) begin
          push       = 1'b1;
          state_next = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        fcnt_next  = fcnt_reg + 8'd1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // Inter-byte timeout only while starved for write-side bytes.
    if (fetch_wait && bus.rx_empty) begin
      if (tmo_reg == TW'(TIMEOUT_CYCLES - 1)) begin
        err_set    = 1'b1;
        state_next = ST_IDLE;
      end else begin
        tmo_next = tmo_reg + TW'(1);
      end
    end

    if (abort_hit) begin
      err_set    = 1'b1;
      state_next = ST_IDLE;
      held_next  = 1'b0;
      pop        = 1'b0;
      we         = 1'b0;
      re         = 1'b0;
      push       = 1'b0;
    end

    if (err_set)
      error_next = 1'b1;
    else if (err_clear)
      error_next = 1'b0;
    else
      error_next = error_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      dir_reg   <= 1'b0;
      addr_reg  <= '0;
      len_reg   <= 8'h00;
      hold_reg  <= 8'h00;
      held_reg  <= 1'b0;
      pend_reg  <= 1'b0;
      tmo_reg   <= '0;
      error_reg <= 1'b0;
      fcnt_reg  <= 8'h00;
`ifdef SPI_SEQ_CHECKSUM_EN
      csum_reg  <= 8'h00;
`endif
    end else begin
      state_reg <= state_next;
      dir_reg   <= dir_next;
      addr_reg  <= addr_next;
      len_reg   <= len_next;
      hold_reg  <= hold_next;
      held_reg  <= held_next;
      pend_reg  <= pop;
      tmo_reg   <= tmo_next;
      error_reg <= error_next;
      fcnt_reg  <= fcnt_next;
`ifdef SPI_SEQ_CHECKSUM_EN
      csum_reg  <= csum_next;
`endif
    end
  end

  assign bus.rx_read   = pop && !reset;
  assign bus.reg_we    = we && !reset;
  assign bus.reg_re    = re && !reset;
  assign bus.tx_write  = push && !reset;
  assign bus.reg_addr  = addr_reg;
  assign bus.reg_wdata = wdata;
  assign bus.tx_data   = tdata;
  assign busy          = (state_reg != ST_IDLE);
  assign error         = error_reg;
  assign frame_count   = fcnt_reg;
endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Scoreboard bench for spi_cmd_sequencer: directed frames feed an RX FIFO model,
// a negedge monitor checks register strobes and TX pushes against queued expectations.
module tb_spi_cmd_sequencer;
  localparam int AW   = 7;
  localparam int K_WE = 0;
  localparam int K_RE = 1;
  localparam int K_TX = 2;

  typedef struct {
    int kind;
    int addr;
    int data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_abort = 1'b0;
  logic       err_clear = 1'b0;
  logic       busy, error;
  logic [7:0] frame_count;

  logic [7:0] rxq[$];
  exp_t       expq[$];
  logic [7:0] regs [128];
  logic       pre_we = 1'b0;
  logic [6:0] pre_addr = 7'h00;
  logic [7:0] pre_data = 8'h00;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         tx_seen = 0;

  spi_cmd_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

  spi_cmd_sequencer #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .bus(bus), .frame_abort(frame_abort),
    .err_clear(err_clear), .busy(busy), .error(error), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // RX FIFO model: data appears the cycle after the pop.
  always @(posedge clk) begin
    if (reset) bus.rx_data <= 8'h00;
    else if (bus.rx_read && rxq.size() > 0) bus.rx_data <= rxq.pop_front();
  end

  initial begin
    bus.rx_empty = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.rx_empty = (rxq.size() == 0);
    end
  end

  // Register bank model with one-cycle read latency.
  always @(posedge clk) begin
    if (pre_we) regs[pre_addr] <= pre_data;
    else if (bus.reg_we) regs[bus.reg_addr] <= bus.reg_wdata;
    if (reset) bus.reg_rdata <= 8'h00;
    else if (bus.reg_re) bus.reg_rdata <= regs[bus.reg_addr];
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input int kind, input int addr, input int data);
    exp_t e;
    n_cmp++;
    if (expq.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected strobe: kind=%0d addr=0x%0h data=0x%0h, expected none", kind, addr, data);
    end else begin
      e = expq.pop_front();
      if (e.kind != kind || e.addr != addr || e.data != data) begin
        n_bad++;
        $display("FAIL strobe: got kind=%0d addr=0x%0h data=0x%0h, expected kind=%0d addr=0x%0h data=0x%0h",
                 kind, addr, data, e.kind, e.addr, e.data);
      end else begin
        $display("txn kind=%0d addr=0x%02h data=0x%02h ok", kind, addr, data);
      end
    end
  endtask

  // Monitor: every strobe the DUT presents is checked against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.reg_we) sb_check(K_WE, int'(bus.reg_addr), int'(bus.reg_wdata));
        if (bus.reg_re) sb_check(K_RE, int'(bus.reg_addr), 0);
        if (bus.tx_write) begin
          if (bus.tx_full) begin
            n_cmp++;
            n_bad++;
            $display("FAIL tx_write_while_full: got tx_write=1, expected 0");
          end
          sb_check(K_TX, 0, int'(bus.tx_data));
          tx_seen++;
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_push(input int kind, input int addr, input int data);
    exp_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    expq.push_back(e);
  endtask

  task automatic preload(input logic [6:0] a, input logic [7:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    cycles(1);
    pre_we   = 1'b0;
  endtask

  // Payload bytes are packed MSB-first in dv; only n_sent of them are delivered.
  task automatic write_frame(input logic [7:0] hdr, input int n, input logic [31:0] dv, input int n_sent);
    logic [7:0] ck, b;
    int a;
    a  = int'(hdr[6:0]);
    ck = hdr ^ 8'(n);
    rxq.push_back(hdr);
    rxq.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      b  = dv[31-8*i -: 8];
      ck = ck ^ b;
      if (i < n_sent) begin
        rxq.push_back(b);
        exp_push(K_WE, (a + i) % 128, int'(b));
      end
    end
`ifdef SPI_SEQ_CHECKSUM_EN
    if (n_sent == n) rxq.push_back(ck);
`endif
  endtask

  task automatic read_frame(input logic [7:0] hdr, input int n, input logic [31:0] dv);
    logic [7:0] ck, b;
    int a;
    a  = int'(hdr[6:0]);
    ck = hdr ^ 8'(n);
    rxq.push_back(hdr);
    rxq.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      b  = dv[31-8*i -: 8];
      ck = ck ^ b;
      exp_push(K_RE, (a + i) % 128, 0);
      exp_push(K_TX, 0, int'(b));
    end
`ifdef SPI_SEQ_CHECKSUM_EN
    exp_push(K_TX, 0, int'(ck));
`endif
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while ((expq.size() != 0 || rxq.size() != 0 || busy) && k < 400) begin
      cycles(1);
      k++;
    end
    n_cmp++;
    if (k >= 400) begin
      n_bad++;
      $display("FAIL %s_done: still %0d expected strobes after 400 cycles, expected 0", tag, expq.size());
    end
    cycles(2);
  endtask

  initial begin
    int k, s;
    bus.tx_full = 1'b0;
    cycles(3);
    reset = 1'b0;
    check("reset_busy", int'(busy), 0);
    check("reset_error", int'(error), 0);
    check("reset_fcnt", int'(frame_count), 0);
    check("reset_strobes", int'({bus.rx_read, bus.reg_we, bus.reg_re, bus.tx_write}), 0);

    // Basic write frame.
    write_frame(8'h85, 2, 32'hAA55_0000, 2);
    wait_done("write");
    check("write_fcnt", int'(frame_count), 1);
    check("write_error", int'(error), 0);

    // Read with address wrap 0x7F -> 0x00.
    preload(7'h7F, 8'h11);
    preload(7'h00, 8'h22);
    read_frame(8'h7F, 2, 32'h1122_0000);
    wait_done("read_wrap");
    check("read_fcnt", int'(frame_count), 2);

    // Backpressure on the second push.
    preload(7'h10, 8'hA1);
    preload(7'h11, 8'hB2);
    preload(7'h12, 8'hC3);
    s = tx_seen;
    read_frame(8'h10, 3, 32'hA1B2_C300);
    k = 0;
    while (tx_seen == s && k < 100) begin
      cycles(1);
      k++;
    end
    check("bp_first_push_seen", int'(tx_seen != s), 1);
    bus.tx_full = 1'b1;
    cycles(20);
    check("bp_still_busy", int'(busy), 1);
    bus.tx_full = 1'b0;
    wait_done("backpressure");
    check("bp_error", int'(error), 0);
    check("bp_fcnt", int'(frame_count), 3);

    // Timeout with only a header byte.
    rxq.push_back(8'h81);
    cycles(6);
    check("tmo_early_busy", int'(busy), 1);
    check("tmo_early_error", int'(error), 0);
    k = 0;
    while (!error && k < 40) begin
      cycles(1);
      k++;
    end
    check("tmo_error", int'(error), 1);
    check("tmo_busy", int'(busy), 0);
    check("tmo_fcnt", int'(frame_count), 3);
    err_clear = 1'b1;
    cycles(1);
    err_clear = 1'b0;
    check("tmo_err_clear", int'(error), 0);

    // Abort in WR_FETCH after two of four writes.
    write_frame(8'hA0, 4, 32'h0102_0304, 2);
    k = 0;
    while (expq.size() != 0 && k < 100) begin
      cycles(1);
      k++;
    end
    cycles(2);
    frame_abort = 1'b1;
    cycles(1);
    frame_abort = 1'b0;
    check("abort_error", int'(error), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_fcnt", int'(frame_count), 3);
    cycles(20);
    err_clear = 1'b1;
    cycles(1);
    err_clear = 1'b0;

    // Same partial frame, cut by reset.
    write_frame(8'hA0, 4, 32'h0102_0304, 2);
    k = 0;
    while (expq.size() != 0 && k < 100) begin
      cycles(1);
      k++;
    end
    cycles(2);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_error", int'(error), 0);
    check("rst_fcnt", int'(frame_count), 0);
    check("rst_strobes", int'({bus.rx_read, bus.reg_we, bus.reg_re, bus.tx_write}), 0);
    check("rst_addr", int'(bus.reg_addr), 0);
    cycles(20);

    // Fresh frame after reset.
    write_frame(8'h81, 1, 32'h3C00_0000, 1);
    wait_done("post_reset");
    check("post_rst_fcnt", int'(frame_count), 1);
    check("post_rst_error", int'(error), 0);

`ifdef SPI_SEQ_CHECKSUM_EN
    // Bad checksum: write stands, frame counts, error latches.
    rxq.push_back(8'h81);
    rxq.push_back(8'h01);
    rxq.push_back(8'h3C);
    rxq.push_back(8'h00);
    exp_push(K_WE, 1, 8'h3C);
    wait_done("bad_cksum");
    check("bad_ck_error", int'(error), 1);
    check("bad_ck_fcnt", int'(frame_count), 2);
`endif

    check("sb_leftover", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
